// File: rtl/ad_ip_jesd204_tpl_dac_pkg.sv
// ----------------------------------------------------------------------------
// ad_ip_jesd204_tpl_dac_pkg
//
// Shared definitions for the TPL DAC pattern channel:
//   - source-select codes driven on dac_data_sel / dac_sel_active
//   - channel FSM state encoding (IDLE / RUN / MUTE)
//   - clog2_min1 helper for address widths that never collapse to zero bits
// ----------------------------------------------------------------------------
package ad_ip_jesd204_tpl_dac_pkg;

    // Source-select codes; 8..15 fall through to zero output.
    localparam logic [3:0] SEL_DMA      = 4'd0;
    localparam logic [3:0] SEL_PAT      = 4'd1;
    localparam logic [3:0] SEL_RAMP     = 4'd2;
    localparam logic [3:0] SEL_ZERO     = 4'd3;
    localparam logic [3:0] SEL_PN7      = 4'd4;
    localparam logic [3:0] SEL_PN15     = 4'd5;
    localparam logic [3:0] SEL_PN7_INV  = 4'd6;
    localparam logic [3:0] SEL_PN15_INV = 4'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_MUTE = 2'd2
    } dac_state_t;

    // Ceiling log2, clamped to at least 1 so single-entry ranges still get a
    // legal one-bit index.
    function automatic int clog2_min1(input int value);
        int width;
        width = 0;
        while ((1 << width) < value) begin
            width = width + 1;
        end
        if (width < 1) begin
            width = 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/ad_ip_jesd204_tpl_dac_pat_mem.sv
// ----------------------------------------------------------------------------
// ad_ip_jesd204_tpl_dac_pat_mem
//
// Banked arbitrary-pattern RAM. Sample address a lives in bank (a mod DPW),
// row (a / DPW), so one row read returns DPW consecutive samples with the
// lowest address in the LSB lane.
//
// Ports:
//   clk      core clock
//   wr_en    single-sample write strobe
//   wr_addr  sample address
//   wr_data  sample value (CONVERTER_RESOLUTION bits)
//   rd_row   row to read; data is registered (one cycle latency)
//   rd_data  DPW samples of the addressed row, lane 0 in LSBs
//
// A read and write of the same row in the same cycle returns the old data.
// Contents are never reset.
// ----------------------------------------------------------------------------
module ad_ip_jesd204_tpl_dac_pat_mem
    import ad_ip_jesd204_tpl_dac_pkg::*;
#(
    parameter int DATA_PATH_WIDTH      = 4,
    parameter int CONVERTER_RESOLUTION = 16,
    parameter int PAT_DEPTH            = 64
) (
    input  logic                                                 clk,
    input  logic                                                 wr_en,
    input  logic [clog2_min1(PAT_DEPTH)-1:0]                     wr_addr,
    input  logic [CONVERTER_RESOLUTION-1:0]                      wr_data,
    input  logic [clog2_min1(PAT_DEPTH/DATA_PATH_WIDTH)-1:0]     rd_row,
    output logic [DATA_PATH_WIDTH*CONVERTER_RESOLUTION-1:0]      rd_data
);

    localparam int DPW   = DATA_PATH_WIDTH;
    localparam int CR    = CONVERTER_RESOLUTION;
    localparam int ROWS  = PAT_DEPTH / DPW;
    localparam int ROW_W = clog2_min1(ROWS);

    int               wr_bank;
    logic [ROW_W-1:0] wr_row;

    always_comb begin
        wr_bank = int'(wr_addr) % DPW;
        wr_row  = ROW_W'(int'(wr_addr) / DPW);
    end

    for (genvar b = 0; b < DPW; b++) begin : g_bank
        logic [CR-1:0] mem [ROWS];
        logic [CR-1:0] rd_q;

        always_ff @(posedge clk) begin
            if (wr_en && (wr_bank == b)) begin
                mem[wr_row] <= wr_data;
            end
            rd_q <= mem[rd_row];
        end

        assign rd_data[b*CR +: CR] = rd_q;
    end

endmodule

// File: rtl/ad_ip_jesd204_tpl_dac_pat_channel.sv
// ----------------------------------------------------------------------------
// ad_ip_jesd204_tpl_dac_pat_channel
//
// One TPL DAC converter channel. Selects DMA, pattern buffer, ramp, zero or
// PN data and drives DATA_PATH_WIDTH samples per clock with a fixed two-cycle
// latency. A source change mutes the output for MUTE_CYCLES and flushes
// whatever was in flight before the new source starts from row 0 / base 0.
//
// Ports:
//   clk, resetn        core clock, asynchronous active-low reset
//   dma_data           DMA samples, lane i at [i*BPS +: CR]
//   pn7_data/pn15_data PN sequences, DPW*CR
//   dac_data_sync      restart pattern pointer and ramp
//   dac_data_sel       requested source
//   ramp_step          ramp increment (low CR bits)
//   pat_wr_*           pattern buffer write port (sample addressed)
//   pat_last_row       last row played before the pointer wraps
//   dac_data           converter samples, lane 0 in LSBs
//   dac_enable         DMA data is being played
//   dac_sel_active     source currently driving the output
//   dac_switching      output is muted for a source change
// ----------------------------------------------------------------------------
module ad_ip_jesd204_tpl_dac_pat_channel
    import ad_ip_jesd204_tpl_dac_pkg::*;
#(
    parameter int DATA_PATH_WIDTH      = 4,
    parameter int CONVERTER_RESOLUTION = 16,
    parameter int BITS_PER_SAMPLE      = 16,
    parameter int PAT_DEPTH            = 64,
    parameter int MUTE_CYCLES          = 4
) (
    input  logic                                              clk,
    input  logic                                              resetn,
    input  logic [DATA_PATH_WIDTH*BITS_PER_SAMPLE-1:0]        dma_data,
    input  logic [DATA_PATH_WIDTH*CONVERTER_RESOLUTION-1:0]   pn7_data,
    input  logic [DATA_PATH_WIDTH*CONVERTER_RESOLUTION-1:0]   pn15_data,
    input  logic                                              dac_data_sync,
    input  logic [3:0]                                        dac_data_sel,
    input  logic [15:0]                                       ramp_step,
    input  logic                                              pat_wr_en,
    input  logic [clog2_min1(PAT_DEPTH)-1:0]                  pat_wr_addr,
    input  logic [15:0]                                       pat_wr_data,
    input  logic [clog2_min1(PAT_DEPTH/DATA_PATH_WIDTH)-1:0]  pat_last_row,
    output logic [DATA_PATH_WIDTH*CONVERTER_RESOLUTION-1:0]   dac_data,
    output logic                                              dac_enable,
    output logic [3:0]                                        dac_sel_active,
    output logic                                              dac_switching
);

    localparam int DPW    = DATA_PATH_WIDTH;
    localparam int CR     = CONVERTER_RESOLUTION;
    localparam int BPS    = BITS_PER_SAMPLE;
    localparam int ROWS   = PAT_DEPTH / DPW;
    localparam int ROW_W  = clog2_min1(ROWS);
    localparam int WORD_W = DPW * CR;

    localparam logic [7:0]       MUTE_LOAD = 8'(MUTE_CYCLES - 1);
    localparam logic [ROW_W-1:0] ROW_MAX   = ROW_W'(ROWS - 1);

    dac_state_t        state_q, state_d;
    logic [3:0]        active_sel_q, active_sel_d;
    logic [7:0]        mute_cnt_q, mute_cnt_d;
    logic [ROW_W-1:0]  ptr_q, ptr_d;
    logic [CR-1:0]     ramp_base_q, ramp_base_d;

    logic              switch_req;
    logic              ptr_wrap;
    logic [CR-1:0]     step_cr;
    logic [CR-1:0]     ramp_adv;

    logic              vld_p0;
    logic [WORD_W-1:0] word_p0;
    logic              vld_p1_d, vld_p1_q;
    logic [3:0]        sel_p1_d, sel_p1_q;
    logic [WORD_W-1:0] word_p1_d, word_p1_q;
    logic [WORD_W-1:0] pat_row_p1;

    logic [WORD_W-1:0] dac_data_d, dac_data_q;
    logic              dac_enable_d, dac_enable_q;

    assign step_cr    = ramp_step[CR-1:0];
    assign ramp_adv   = step_cr * CR'(DPW);
    assign switch_req = (state_q == ST_RUN) && (dac_data_sel != active_sel_q);
    // ROW_MAX guard keeps the pointer inside the RAM even when pat_last_row
    // is programmed past the last physical row.
    assign ptr_wrap   = (ptr_q >= pat_last_row) || (ptr_q == ROW_MAX);

    // Channel FSM, row pointer and ramp base. A sel change in RUN takes
    // priority over sync; MUTE exit clears pointer and ramp anyway.
    always_comb begin
        state_d      = state_q;
        active_sel_d = active_sel_q;
        mute_cnt_d   = mute_cnt_q;
        ptr_d        = ptr_q;
        ramp_base_d  = ramp_base_q;
        case (state_q)
            ST_IDLE: begin
                if (dac_data_sync) begin
                    state_d      = ST_RUN;
                    active_sel_d = dac_data_sel;
                    ptr_d        = '0;
                    ramp_base_d  = '0;
                end
            end
            ST_RUN: begin
                ptr_d       = ptr_wrap ? '0 : ptr_q + ROW_W'(1);
                ramp_base_d = ramp_base_q + ramp_adv;
                if (switch_req) begin
                    state_d    = ST_MUTE;
                    mute_cnt_d = MUTE_LOAD;
                end else if (dac_data_sync) begin
                    ptr_d       = '0;
                    ramp_base_d = '0;
                end
            end
            ST_MUTE: begin
                if (mute_cnt_q == 8'd0) begin
                    state_d      = ST_RUN;
                    active_sel_d = dac_data_sel;
                    ptr_d        = '0;
                    ramp_base_d  = '0;
                end else begin
                    mute_cnt_d = mute_cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ---- p0: non-RAM source selection, RAM row read issued ----
    always_comb begin
        word_p0 = '0;
        for (int i = 0; i < DPW; i++) begin
            case (active_sel_q)
                SEL_DMA:      word_p0[i*CR +: CR] = dma_data[i*BPS +: CR];
                SEL_RAMP:     word_p0[i*CR +: CR] = ramp_base_q + step_cr * CR'(i);
                SEL_PN7:      word_p0[i*CR +: CR] = pn7_data[i*CR +: CR];
                SEL_PN15:     word_p0[i*CR +: CR] = pn15_data[i*CR +: CR];
                SEL_PN7_INV:  word_p0[i*CR +: CR] = ~pn7_data[i*CR +: CR];
                SEL_PN15_INV: word_p0[i*CR +: CR] = ~pn15_data[i*CR +: CR];
                default:      word_p0[i*CR +: CR] = '0;
            endcase
        end
    end

    // The cycle that detects a sel change is already stale, so it is never
    // marked valid.
    assign vld_p0    = (state_q == ST_RUN) && !switch_req;
    assign vld_p1_d  = vld_p0;
    assign sel_p1_d  = active_sel_q;
    assign word_p1_d = word_p0;

    ad_ip_jesd204_tpl_dac_pat_mem #(
        .DATA_PATH_WIDTH      (DPW),
        .CONVERTER_RESOLUTION (CR),
        .PAT_DEPTH            (PAT_DEPTH)
    ) i_pat_mem (
        .clk     (clk),
        .wr_en   (pat_wr_en),
        .wr_addr (pat_wr_addr),
        .wr_data (pat_wr_data[CR-1:0]),
        .rd_row  (ptr_q),
        .rd_data (pat_row_p1)
    );

    // ---- p1: final mux into the output register ----
    // switch_req also kills the word already in p1 so the output goes to zero
    // on the very next cycle after a sel change.
    always_comb begin
        dac_data_d   = '0;
        dac_enable_d = 1'b0;
        if (vld_p1_q && !switch_req) begin
            dac_data_d   = (sel_p1_q == SEL_PAT) ? pat_row_p1 : word_p1_q;
            dac_enable_d = (sel_p1_q == SEL_DMA);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            active_sel_q <= SEL_ZERO;
            mute_cnt_q   <= '0;
            ptr_q        <= '0;
            ramp_base_q  <= '0;
            vld_p1_q     <= 1'b0;
            sel_p1_q     <= SEL_ZERO;
            dac_data_q   <= '0;
            dac_enable_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            active_sel_q <= active_sel_d;
            mute_cnt_q   <= mute_cnt_d;
            ptr_q        <= ptr_d;
            ramp_base_q  <= ramp_base_d;
            vld_p1_q     <= vld_p1_d;
            sel_p1_q     <= sel_p1_d;
            dac_data_q   <= dac_data_d;
            dac_enable_q <= dac_enable_d;
        end
    end

    always_ff @(posedge clk) begin
        word_p1_q <= word_p1_d;
    end

    assign dac_data       = dac_data_q;
    assign dac_enable     = dac_enable_q;
    assign dac_sel_active = active_sel_q;
    assign dac_switching  = (state_q == ST_MUTE);

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_dac_pat_channel.sv
module tb_ad_ip_jesd204_tpl_dac_pat_channel;

    localparam int DPW  = 4;
    localparam int MUTE = 4;

    logic        clk           = 1'b0;
    logic        resetn        = 1'b1;
    logic [63:0] dma_data      = '0;
    logic [63:0] pn7_data      = '0;
    logic [63:0] pn15_data     = '0;
    logic        dac_data_sync = 1'b0;
    logic [3:0]  dac_data_sel  = 4'd3;
    logic [15:0] ramp_step     = '0;
    logic        pat_wr_en     = 1'b0;
    logic [3:0]  pat_wr_addr   = '0;
    logic [15:0] pat_wr_data   = '0;
    logic [1:0]  pat_last_row  = '0;
    logic [63:0] dac_data;
    logic        dac_enable;
    logic [3:0]  dac_sel_active;
    logic        dac_switching;

    ad_ip_jesd204_tpl_dac_pat_channel #(
        .DATA_PATH_WIDTH      (4),
        .CONVERTER_RESOLUTION (16),
        .BITS_PER_SAMPLE      (16),
        .PAT_DEPTH            (16),
        .MUTE_CYCLES          (MUTE)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .dma_data       (dma_data),
        .pn7_data       (pn7_data),
        .pn15_data      (pn15_data),
        .dac_data_sync  (dac_data_sync),
        .dac_data_sel   (dac_data_sel),
        .ramp_step      (ramp_step),
        .pat_wr_en      (pat_wr_en),
        .pat_wr_addr    (pat_wr_addr),
        .pat_wr_data    (pat_wr_data),
        .pat_last_row   (pat_last_row),
        .dac_data       (dac_data),
        .dac_enable     (dac_enable),
        .dac_sel_active (dac_sel_active),
        .dac_switching  (dac_switching)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; logic [63:0] data; logic en; } dexp_t;
    typedef struct { int cyc; logic sw; logic [3:0] sel; } cexp_t;
    dexp_t dq[$];
    cexp_t cq[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Tracks the channel at the level of "what word does the active source
    // contribute this cycle" and "which cycles are muted".
    typedef enum { M_IDLE, M_RUN, M_MUTE } mmode_t;
    mmode_t      m_mode      = M_IDLE;
    int          m_active    = 3;
    int          m_mute_left = 0;
    int          m_row       = 0;
    logic [15:0] m_base      = '0;
    logic [15:0] m_ram [16];

    function automatic logic [63:0] source_word();
        logic [63:0] w;
        w = '0;
        for (int i = 0; i < DPW; i++) begin
            case (m_active)
                0: w[i*16 +: 16] = dma_data[i*16 +: 16];
                1: w[i*16 +: 16] = m_ram[m_row*DPW + i];
                2: w[i*16 +: 16] = m_base + 16'(i) * ramp_step;
                4: w[i*16 +: 16] = pn7_data[i*16 +: 16];
                5: w[i*16 +: 16] = pn15_data[i*16 +: 16];
                6: w[i*16 +: 16] = ~pn7_data[i*16 +: 16];
                7: w[i*16 +: 16] = ~pn15_data[i*16 +: 16];
                default: w[i*16 +: 16] = 16'h0000;
            endcase
        end
        return w;
    endfunction

    task automatic model_reset();
        m_mode      = M_IDLE;
        m_active    = 3;
        m_mute_left = 0;
        m_row       = 0;
        m_base      = '0;
    endtask

    // Called once per cycle with that cycle's inputs applied; pushes the
    // expected output word for cycle+2 and control outputs for cycle+1.
    task automatic model_step();
        logic [63:0] w;
        logic        en;
        int          sel;
        w   = '0;
        en  = 1'b0;
        sel = int'(dac_data_sel);
        case (m_mode)
            M_IDLE: begin
                if (dac_data_sync) begin
                    m_mode = M_RUN; m_active = sel; m_row = 0; m_base = '0;
                end
            end
            M_RUN: begin
                if (sel != m_active) begin
                    // mute starts next cycle and blanks the word already in flight
                    foreach (dq[i]) if (dq[i].cyc == cyc + 1) begin
                        dq[i].data = '0;
                        dq[i].en   = 1'b0;
                    end
                    m_mode = M_MUTE;
                    m_mute_left = MUTE;
                end else begin
                    w  = source_word();
                    en = (m_active == 0);
                    m_row  = (m_row >= int'(pat_last_row)) ? 0 : m_row + 1;
                    m_base = m_base + 16'(DPW) * ramp_step;
                    if (dac_data_sync) begin
                        m_row = 0; m_base = '0;
                    end
                end
            end
            M_MUTE: begin
                m_mute_left--;
                if (m_mute_left == 0) begin
                    m_mode = M_RUN; m_active = sel; m_row = 0; m_base = '0;
                end
            end
            default: ;
        endcase
        if (pat_wr_en) m_ram[pat_wr_addr] = pat_wr_data;
        dq.push_back('{cyc: cyc + 2, data: w, en: en});
        cq.push_back('{cyc: cyc + 1, sw: (m_mode == M_MUTE), sel: 4'(m_active)});
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin : monitor
        dexp_t de;
        cexp_t ce;
        while (dq.size() > 0 && dq[0].cyc <= cyc) begin
            de = dq.pop_front();
            if (de.cyc == cyc) begin
                check("dac_data", dac_data, de.data);
                check("dac_enable", 64'(dac_enable), 64'(de.en));
            end else begin
                check("stale_data_exp", 64'(de.cyc), 64'(cyc));
            end
        end
        while (cq.size() > 0 && cq[0].cyc <= cyc) begin
            ce = cq.pop_front();
            if (ce.cyc == cyc) begin
                check("dac_switching", 64'(dac_switching), 64'(ce.sw));
                check("dac_sel_active", 64'(dac_sel_active), 64'(ce.sel));
            end else begin
                check("stale_ctrl_exp", 64'(ce.cyc), 64'(cyc));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_data();
        dma_data  = {$urandom, $urandom};
        pn7_data  = {$urandom, $urandom};
        pn15_data = {$urandom, $urandom};
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_dac_data"}, dac_data, 64'h0);
        check({tag, "_dac_enable"}, 64'(dac_enable), 64'h0);
        check({tag, "_dac_sel_active"}, 64'(dac_sel_active), 64'h3);
        check({tag, "_dac_switching"}, 64'(dac_switching), 64'h0);
    endtask

    initial begin
        #1 resetn = 1'b0;
        @(posedge clk); #1;
        check_reset_outputs("reset");
        @(posedge clk); #1;
        resetn = 1'b1;

        // DMA playback
        dac_data_sel = 4'd0; dac_data_sync = 1'b1; rand_data(); tick();
        dac_data_sync = 1'b0; rand_data(); dma_data = 64'h0004_0003_0002_0001; tick();
        repeat (6) begin rand_data(); tick(); end

        // load pattern while DMA keeps playing
        for (int k = 0; k < 16; k++) begin
            pat_wr_en = 1'b1; pat_wr_addr = 4'(k); pat_wr_data = 16'(16'h100 + k);
            rand_data(); tick();
        end
        pat_wr_en = 1'b0;

        // switch to pattern, then sync
        pat_last_row = 2'd2; dac_data_sel = 4'd1;
        repeat (8) begin rand_data(); tick(); end
        dac_data_sync = 1'b1; tick(); dac_data_sync = 1'b0;
        repeat (8) begin rand_data(); tick(); end

        // switch 1 -> 2 into a ramp whose base wraps every cycle
        ramp_step = 16'h4000; dac_data_sel = 4'd2;
        repeat (10) begin rand_data(); tick(); end

        // sync together with a sel change
        dac_data_sel = 4'd1; dac_data_sync = 1'b1; tick(); dac_data_sync = 1'b0;
        repeat (9) begin rand_data(); tick(); end

        // sel toggled away and back during mute
        dac_data_sel = 4'd0; tick();
        dac_data_sel = 4'd1;
        repeat (9) begin rand_data(); tick(); end

        // randomized traffic
        repeat (250) begin
            rand_data();
            if ($urandom_range(7) == 0)
                dac_data_sel = ($urandom_range(3) == 0) ? 4'($urandom_range(15)) : 4'($urandom_range(7));
            dac_data_sync = ($urandom_range(7) == 0);
            pat_wr_en     = ($urandom_range(3) == 0);
            pat_wr_addr   = 4'($urandom_range(15));
            pat_wr_data   = 16'($urandom);
            if ($urandom_range(15) == 0) pat_last_row = 2'($urandom_range(3));
            if ($urandom_range(15) == 0) ramp_step = 16'($urandom);
            tick();
        end

        // reset in the middle of pattern playback
        dac_data_sync = 1'b0; pat_wr_en = 1'b0; dac_data_sel = 4'd1; pat_last_row = 2'd3;
        repeat (8) begin rand_data(); tick(); end
        dac_data_sync = 1'b1; tick(); dac_data_sync = 1'b0;
        repeat (3) begin rand_data(); tick(); end
        #2 resetn = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        dq.delete();
        cq.delete();
        model_reset();
        @(posedge clk); #1;
        check_reset_outputs("held_reset");
        @(posedge clk); #1;
        resetn = 1'b1;
        dac_data_sync = 1'b1; tick(); dac_data_sync = 1'b0;
        repeat (8) begin rand_data(); tick(); end

        repeat (3) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
